// File: rtl/delay_phase_planner.sv
// Splits a fine-step delay into whole clock cycles plus a signed fine phase,
// programs the phase stepper when the fine part changes, then publishes the coarse count.
module delay_phase_planner #(
  parameter int DELAY_WIDTH     = 32,
  parameter int PHASE_WIDTH     = 32,
  parameter int COARSE_WIDTH    = 16,
  parameter int STEPS_PER_CYCLE = 560
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [DELAY_WIDTH-1:0]  req_delay,
  input  logic                    req_valid,
  output logic                    req_ready,
  output logic [PHASE_WIDTH-1:0]  target,
  output logic                    configure,
  input  logic                    configured,
  output logic [COARSE_WIDTH-1:0] coarse_cycles,
  output logic                    plan_valid,
  output logic                    plan_err,
  output logic                    busy
);

  localparam int REM_W = $clog2(STEPS_PER_CYCLE) + 1;
  localparam int CNT_W = $clog2(DELAY_WIDTH);
  localparam logic [REM_W-1:0] DIV_R  = REM_W'(STEPS_PER_CYCLE);
  localparam logic [REM_W-1:0] HALF_R = REM_W'(STEPS_PER_CYCLE / 2);

  typedef enum logic [2:0] {
    S_IDLE, S_DIVIDE, S_ADJUST, S_ISSUE, S_GUARD, S_WAIT_PS, S_DONE
  } state_t;

  state_t                  r_state, w_next;
  logic                    r_live;
  logic [DELAY_WIDTH-1:0]  r_quo;
  logic [REM_W-1:0]        r_rem;
  logic [CNT_W-1:0]        r_cnt;
  logic [COARSE_WIDTH-1:0] r_coarse;
  logic [COARSE_WIDTH-1:0] r_coarse_out;
  logic [PHASE_WIDTH-1:0]  r_target;
  logic [PHASE_WIDTH-1:0]  r_last_fine;

  logic [REM_W-1:0]        w_rem_sh;
  logic                    w_ge;
  logic [REM_W-1:0]        w_rem_nx;
  logic                    w_round;
  logic [PHASE_WIDTH-1:0]  w_fine;
  logic [DELAY_WIDTH:0]    w_coarse_full;
  logic                    w_ovf;
  logic                    w_accept;

  // One restoring-division step: remainder always stays below the divisor.
  assign w_rem_sh = {r_rem[REM_W-2:0], r_quo[DELAY_WIDTH-1]};
  assign w_ge     = (w_rem_sh >= DIV_R);
  assign w_rem_nx = w_ge ? (w_rem_sh - DIV_R) : w_rem_sh;

  // Remainders above half a period wrap to a negative phase on the next cycle.
  assign w_round       = (r_rem > HALF_R);
  assign w_fine        = w_round ? (PHASE_WIDTH'(r_rem) - PHASE_WIDTH'(STEPS_PER_CYCLE))
                                 : PHASE_WIDTH'(r_rem);
  assign w_coarse_full = {1'b0, r_quo} + {{DELAY_WIDTH{1'b0}}, w_round};
  assign w_ovf         = |w_coarse_full[DELAY_WIDTH:COARSE_WIDTH];
  assign w_accept      = req_valid && req_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (w_accept) w_next = S_DIVIDE;
      S_DIVIDE:  if (r_cnt == '0) w_next = S_ADJUST;
      S_ADJUST: begin
        if (w_ovf)                       w_next = S_IDLE;
        else if (w_fine == r_last_fine)  w_next = S_DONE;
        else                             w_next = S_ISSUE;
      end
      S_ISSUE:   w_next = S_GUARD;
      S_GUARD:   if (r_cnt == '0) w_next = S_WAIT_PS;
      S_WAIT_PS: if (configured) w_next = S_DONE;
      S_DONE:    w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready  = (r_state == S_IDLE) && r_live;
    busy       = (r_state != S_IDLE);
    configure  = (r_state == S_ISSUE);
    plan_valid = (r_state == S_DONE);
    plan_err   = (r_state == S_ADJUST) && w_ovf;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_live       <= 1'b0;
      r_quo        <= '0;
      r_rem        <= '0;
      r_cnt        <= '0;
      r_coarse     <= '0;
      r_coarse_out <= '0;
      r_target     <= '0;
      r_last_fine  <= '0;
    end else begin
      r_live <= 1'b1;
      case (r_state)
        S_IDLE: if (w_accept) begin
          r_quo <= req_delay;
          r_rem <= '0;
          r_cnt <= CNT_W'(DELAY_WIDTH - 1);
        end
        S_DIVIDE: begin
          r_quo <= {r_quo[DELAY_WIDTH-2:0], w_ge};
          r_rem <= w_rem_nx;
          r_cnt <= r_cnt - 1'b1;
        end
        S_ADJUST: begin
          r_coarse <= w_coarse_full[COARSE_WIDTH-1:0];
          r_cnt    <= CNT_W'(1);
          // Target is loaded on entry so it is already valid during the configure pulse.
          if (w_next == S_ISSUE) begin
            r_target    <= w_fine;
            r_last_fine <= w_fine;
          end
          if (w_next == S_DONE) r_coarse_out <= w_coarse_full[COARSE_WIDTH-1:0];
        end
        S_GUARD:   r_cnt <= r_cnt - 1'b1;
        S_WAIT_PS: if (configured) r_coarse_out <= r_coarse;
        default: ;
      endcase
    end
  end

  assign target        = r_target;
  assign coarse_cycles = r_coarse_out;

endmodule

// File: tb/tb_delay_phase_planner.sv
// Directed + randomized bench for delay_phase_planner with a behavioural phase stepper.
module tb_delay_phase_planner;

  localparam int DW  = 32;
  localparam int PW  = 32;
  localparam int CW  = 4;
  localparam int SPC = 560;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] req_delay = '0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [PW-1:0] target;
  logic          configure;
  logic          configured;
  logic [CW-1:0] coarse_cycles;
  logic          plan_valid;
  logic          plan_err;
  logic          busy;

  always #5 clk = ~clk;

  delay_phase_planner #(
    .DELAY_WIDTH(DW), .PHASE_WIDTH(PW), .COARSE_WIDTH(CW), .STEPS_PER_CYCLE(SPC)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req_delay(req_delay), .req_valid(req_valid),
    .req_ready(req_ready), .target(target), .configure(configure),
    .configured(configured), .coarse_cycles(coarse_cycles),
    .plan_valid(plan_valid), .plan_err(plan_err), .busy(busy)
  );

  // Stepper: drops configured right after a configure pulse, stays low for 5 cycles.
  int st_cnt;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)          st_cnt <= 0;
    else if (configure)  st_cnt <= 5;
    else if (st_cnt > 0) st_cnt <= st_cnt - 1;
  end
  assign configured = (st_cnt == 0);

  typedef struct {
    logic [CW-1:0] coarse;
    logic [PW-1:0] tgt;
    int            cfg;
    bit            err;
  } exp_t;

  exp_t          sb[$];
  int            n_vec = 0;
  int            n_bad = 0;
  int            m_coarse = 0;
  int            m_last = 0;
  logic [PW-1:0] m_tgt = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [CW-1:0] c, input logic [PW-1:0] t, input int cfg, input bit err);
    exp_t e;
    e.coarse = c; e.tgt = t; e.cfg = cfg; e.err = err;
    sb.push_back(e);
  endtask

  // Reference split using plain integer divide/modulo.
  task automatic push_model(input int d);
    int q, r, f;
    q = d / SPC;
    r = d % SPC;
    if (r > SPC / 2) begin f = r - SPC; q++; end
    else f = r;
    if (q >= (1 << CW)) push(CW'(m_coarse), m_tgt, 0, 1);
    else if (f == m_last) begin m_coarse = q; push(CW'(q), m_tgt, 0, 0); end
    else begin m_coarse = q; m_last = f; m_tgt = PW'(f); push(CW'(q), PW'(f), 1, 0); end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_target"}, target, 0);
    chk({tag, "_outs"}, {28'd0, configure, plan_valid, plan_err, busy}, 0);
    chk({tag, "_coarse"}, coarse_cycles, 0);
  endtask

  task automatic run(input int d, input bit glitch);
    exp_t e;
    int   cyc = 0;
    int   ncfg = 0;
    bit   done = 0;
    bit   both = 0;
    @(negedge clk);
    chk("req_ready", req_ready, 1);
    req_delay = DW'(d);
    req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    while (!done && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (glitch && cyc == 10) begin req_valid = 1'b1; req_delay = 32'd999; end
      else req_valid = 1'b0;
      if (configure) ncfg++;
      if (plan_valid && plan_err) both = 1;
      if (plan_valid || plan_err) done = 1;
    end
    e = sb.pop_front();
    chk("timeout", {31'd0, done}, 1);
    chk("valid_and_err", {31'd0, both}, 0);
    chk("plan_err", {31'd0, plan_err}, {31'd0, e.err});
    chk("coarse", coarse_cycles, e.coarse);
    chk("target", target, e.tgt);
    chk("cfg_pulses", ncfg, e.cfg);
    if (!e.err && e.cfg == 0) chk("skip_latency", cyc, DW + 2);
    @(negedge clk);
    chk("pulse_end", {29'd0, plan_valid, plan_err, busy}, 0);
  endtask

  initial begin
    int cyc;
    repeat (3) @(negedge clk);
    chk("rst_ready", req_ready, 0);
    chk_reset_vals("rst");
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", req_ready, 1);

    push(0, 0, 0, 0);               run(0, 0);
    push(0, 100, 1, 0);             run(100, 0);
    push(0, 280, 1, 0);             run(280, 0);
    push(1, 32'hFFFFFEE9, 1, 0);    run(281, 0);
    push(1, 100, 1, 0);             run(660, 0);
    push(2, 100, 0, 0);             run(1220, 0);
    push(2, 100, 0, 1);             run(16 * SPC, 0);
    push(1, 40, 1, 0);              run(600, 1);

    // Reset while waiting on the stepper.
    @(negedge clk);
    req_delay = 32'd50;
    req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    cyc = 0;
    while (!configure && cyc < 100) begin @(negedge clk); cyc++; end
    chk("mid_cfg_seen", {31'd0, configure}, 1);
    repeat (3) @(negedge clk);
    chk("mid_busy", {31'd0, busy}, 1);
    rst_n = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk_reset_vals("mid_rst");
    end
    rst_n = 1'b1;
    @(negedge clk);
    chk("mid_ready", {30'd0, req_ready, busy}, 2);
    push(0, 50, 1, 0);              run(50, 0);

    m_coarse = 0; m_last = 50; m_tgt = 50;
    push_model(15 * SPC + 280);     run(15 * SPC + 280, 0);
    push_model(15 * SPC + 281);     run(15 * SPC + 281, 0);
    for (int i = 0; i < 8; i++) begin
      int d;
      d = int'($urandom_range(0, 16 * SPC + 300));
      push_model(d); run(d, 0);
      if (i == 3) begin push_model(d); run(d, 0); end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
